// File: rtl/frame_fifo_pkg.sv
// Shared constants for the frame FIFO write/read paths.
// Holds the state encoding and the synchroniser depths.
package frame_fifo_pkg;

  localparam int REQ_SYNC_DEPTH = 3;
  localparam int BUS_SYNC_DEPTH = 2;

  localparam logic [2:0] ST_IDLE            = 3'd0;
  localparam logic [2:0] ST_ACK             = 3'd1;
  localparam logic [2:0] ST_CHECK_FIFO      = 3'd2;
  localparam logic [2:0] ST_WRITE_BURST     = 3'd3;
  localparam logic [2:0] ST_WRITE_BURST_END = 3'd4;
  localparam logic [2:0] ST_END             = 3'd5;

  typedef enum logic [2:0] {
    IDLE            = ST_IDLE,
    ACK             = ST_ACK,
    CHECK_FIFO      = ST_CHECK_FIFO,
    WRITE_BURST     = ST_WRITE_BURST,
    WRITE_BURST_END = ST_WRITE_BURST_END,
    END             = ST_END
  } write_state_t;

endpackage

// File: rtl/sync_bus.sv
// Multi-flop synchroniser for a bus into the mem_clk domain.
// Latency DEPTH cycles; the bus must be stable while it crosses.
module sync_bus #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             mem_clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/frame_fifo_write.sv
// Drains a frame from the FIFO to memory as bursts at a selectable base address.
// FRAME_WRITE_PARTIAL_BURST_EN: trims the final burst to the remaining frame length.
module frame_fifo_write
  import frame_fifo_pkg::*;
#(
  parameter int MEM_DATA_BITS = 32,
  parameter int ADDR_BITS     = 23,
  parameter int BURST_BITS    = 10,
  parameter int BURST_SIZE    = 128
) (
  input  logic                  rst,
  input  logic                  mem_clk,
  output logic                  wr_burst_req,
  output logic [BURST_BITS-1:0] wr_burst_len,
  output logic [ADDR_BITS-1:0]  wr_burst_addr,
  input  logic                  wr_burst_data_req,
  input  logic                  wr_burst_finish,
  output logic                  fifo_rdreq,
  input  logic                  write_req,
  output logic                  write_req_ack,
  output logic                  write_finish,
  input  logic [ADDR_BITS-1:0]  write_addr_0,
  input  logic [ADDR_BITS-1:0]  write_addr_1,
  input  logic [ADDR_BITS-1:0]  write_addr_2,
  input  logic [ADDR_BITS-1:0]  write_addr_3,
  input  logic [1:0]            write_addr_index,
  input  logic [ADDR_BITS-1:0]  write_len,
  output logic                  fifo_aclr,
  input  logic [15:0]           rdusedw
);

  if (MEM_DATA_BITS < 1 || BURST_SIZE >= (1 << BURST_BITS)) begin : g_param_check
    $error("frame_fifo_write: BURST_SIZE must fit in BURST_BITS");
  end

  write_state_t          state, state_nxt;
  logic                  req_sync;
  logic [1:0]            index_sync;
  logic [ADDR_BITS-1:0]  len_sync;
  logic [ADDR_BITS-1:0]  len_latch;
  logic [ADDR_BITS-1:0]  write_cnt;
  logic [ADDR_BITS-1:0]  sel_addr;
  logic [BURST_BITS-1:0] cur_len;
  logic                  fifo_ready;

  sync_bus #(.WIDTH(1), .DEPTH(REQ_SYNC_DEPTH)) u_req_sync (
    .mem_clk(mem_clk), .rst(rst), .d(write_req), .q(req_sync)
  );
  sync_bus #(.WIDTH(2), .DEPTH(BUS_SYNC_DEPTH)) u_index_sync (
    .mem_clk(mem_clk), .rst(rst), .d(write_addr_index), .q(index_sync)
  );
  sync_bus #(.WIDTH(ADDR_BITS), .DEPTH(BUS_SYNC_DEPTH)) u_len_sync (
    .mem_clk(mem_clk), .rst(rst), .d(write_len), .q(len_sync)
  );

  assign fifo_rdreq   = wr_burst_data_req;
  assign write_finish = (state == END);

  always_comb begin
    sel_addr = write_addr_0;
    case (index_sync)
      2'd1:    sel_addr = write_addr_1;
      2'd2:    sel_addr = write_addr_2;
      2'd3:    sel_addr = write_addr_3;
      default: sel_addr = write_addr_0;
    endcase
  end

`ifdef FRAME_WRITE_PARTIAL_BURST_EN
  logic [ADDR_BITS-1:0] remain;
  assign remain  = len_latch - write_cnt;
  assign cur_len = (remain < ADDR_BITS'(BURST_SIZE)) ? BURST_BITS'(remain)
                                                     : BURST_BITS'(BURST_SIZE);
`else
  // Every burst is full size; frame lengths are expected to be multiples of it.
  assign cur_len = BURST_BITS'(BURST_SIZE);
`endif

  assign fifo_ready = 32'(rdusedw) >= 32'(cur_len);

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:            if (req_sync) state_nxt = ACK;
      ACK:             if (!req_sync) state_nxt = CHECK_FIFO;
      CHECK_FIFO: begin
        if (req_sync)        state_nxt = ACK;
        else if (fifo_ready) state_nxt = WRITE_BURST;
      end
      WRITE_BURST:     if (wr_burst_finish) state_nxt = WRITE_BURST_END;
      // A request that arrived mid-burst is only honoured here.
      WRITE_BURST_END: begin
        if (req_sync)                    state_nxt = ACK;
        else if (write_cnt < len_latch)  state_nxt = CHECK_FIFO;
        else                             state_nxt = END;
      end
      END:             state_nxt = IDLE;
      default:         state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      wr_burst_req  <= 1'b0;
      wr_burst_len  <= '0;
      wr_burst_addr <= '0;
      write_req_ack <= 1'b0;
      fifo_aclr     <= 1'b0;
      len_latch     <= '0;
      write_cnt     <= '0;
    end else begin
      case (state)
        IDLE: write_req_ack <= 1'b0;
        ACK: begin
          write_cnt <= '0;
          if (req_sync) begin
            write_req_ack <= 1'b1;
            fifo_aclr     <= 1'b1;
            wr_burst_addr <= sel_addr;
            len_latch     <= len_sync;
          end else begin
            write_req_ack <= 1'b0;
            fifo_aclr     <= 1'b0;
          end
        end
        CHECK_FIFO: begin
          if (!req_sync && fifo_ready) begin
            wr_burst_req <= 1'b1;
            wr_burst_len <= cur_len;
          end
        end
        WRITE_BURST: begin
          if (wr_burst_data_req || wr_burst_finish) wr_burst_req <= 1'b0;
          if (wr_burst_finish) begin
            write_cnt     <= write_cnt + ADDR_BITS'(wr_burst_len);
            wr_burst_addr <= wr_burst_addr + ADDR_BITS'(wr_burst_len);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_fifo_write.sv
// Randomised scoreboard bench for frame_fifo_write with a memory-controller responder.
module tb_frame_fifo_write;

  localparam int AW = 23;
  localparam int BW = 10;

  logic          rst, mem_clk;
  logic          wr_burst_req;
  logic [BW-1:0] wr_burst_len;
  logic [AW-1:0] wr_burst_addr;
  logic          wr_burst_data_req, wr_burst_finish, fifo_rdreq;
  logic          write_req, write_req_ack, write_finish;
  logic [AW-1:0] write_addr_0, write_addr_1, write_addr_2, write_addr_3, write_len;
  logic [1:0]    write_addr_index;
  logic          fifo_aclr;
  logic [15:0]   rdusedw;

  typedef struct {
    logic [AW-1:0] addr;
    int            len;
  } burst_t;

  burst_t exp_q[$];
  int     exp_fin = 0;
  int     bursts_seen = 0;
  int     checks = 0;
  int     errors = 0;

  frame_fifo_write dut (
    .rst(rst), .mem_clk(mem_clk),
    .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len), .wr_burst_addr(wr_burst_addr),
    .wr_burst_data_req(wr_burst_data_req), .wr_burst_finish(wr_burst_finish), .fifo_rdreq(fifo_rdreq),
    .write_req(write_req), .write_req_ack(write_req_ack), .write_finish(write_finish),
    .write_addr_0(write_addr_0), .write_addr_1(write_addr_1),
    .write_addr_2(write_addr_2), .write_addr_3(write_addr_3),
    .write_addr_index(write_addr_index), .write_len(write_len),
    .fifo_aclr(fifo_aclr), .rdusedw(rdusedw)
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: bursts of BURST_SIZE (or the remainder) until the frame length is covered.
  task automatic push_frame(input logic [AW-1:0] base, input int len, input int limit);
    int done = 0;
    int k = 0;
    burst_t b;
    logic [31:0] sum;
    do begin
      int bl;
`ifdef FRAME_WRITE_PARTIAL_BURST_EN
      bl = (len - done < 128) ? len - done : 128;
`else
      bl = 128;
`endif
      sum = 32'(base) + 32'(done);
      b.addr = sum[AW-1:0];
      b.len  = bl;
      if (limit < 0 || k < limit) exp_q.push_back(b);
      done += bl;
      k++;
    end while (done < len);
  endtask

  task automatic do_request(input logic [AW-1:0] base, input logic [1:0] idx,
                            input logic [AW-1:0] len, input int budget);
    bit got = 0;
    write_addr_0 = AW'($urandom());
    write_addr_1 = AW'($urandom());
    write_addr_2 = AW'($urandom());
    write_addr_3 = AW'($urandom());
    case (idx)
      2'd0: write_addr_0 = base;
      2'd1: write_addr_1 = base;
      2'd2: write_addr_2 = base;
      default: write_addr_3 = base;
    endcase
    write_addr_index = idx;
    write_len        = len;
    write_req        = 1'b1;
    for (int n = 0; n < budget && !got; n++) begin
      @(negedge mem_clk);
      if (write_req_ack) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_timeout: no write_req_ack within %0d cycles, required 1", budget);
    end
    @(posedge mem_clk); #1;
    write_req = 1'b0;
  endtask

  task automatic wait_finish(input string name, input int budget);
    int n = 0;
    while (exp_fin != 0 && n < budget) begin
      @(posedge mem_clk);
      n++;
    end
    #2;
    checks++;
    if (exp_fin != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d frame finishes pending after %0d cycles, required 0", name, exp_fin, budget);
      exp_fin = 0;
      exp_q.delete();
    end
    repeat (3) @(posedge mem_clk);
  endtask

  task automatic monitor_loop();
    logic req_q = 1'b0;
    logic ack_q = 1'b0;
    burst_t e;
    forever begin
      @(negedge mem_clk);
      if (!rst) begin
        check("fifo_rdreq_follow", 64'(fifo_rdreq), 64'(wr_burst_data_req));
        if (wr_burst_req && !req_q) begin
          bursts_seen++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_burst: addr 0x%0h len %0d, required none", wr_burst_addr, wr_burst_len);
          end else begin
            e = exp_q.pop_front();
            check("burst_addr", 64'(wr_burst_addr), 64'(e.addr));
            check("burst_len", 64'(wr_burst_len), 64'(e.len));
          end
        end
        if (write_req_ack && !ack_q) check("aclr_with_ack", 64'(fifo_aclr), 64'd1);
        if (write_finish) begin
          if (exp_fin == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_finish: write_finish=1, required 0");
          end else begin
            exp_fin--;
            check("bursts_left_at_finish", 64'(exp_q.size()), 64'd0);
          end
        end
      end
      req_q = wr_burst_req;
      ack_q = write_req_ack;
    end
  endtask

  // Memory controller: random gap, then one data pull per word, then a finish pulse.
  task automatic ctrl_loop();
    int cstate = 0;
    int remaining = 0;
    int gap = 0;
    forever begin
      @(posedge mem_clk); #1;
      if (rst) begin
        wr_burst_data_req = 1'b0;
        wr_burst_finish   = 1'b0;
        cstate = 0;
      end else begin
        case (cstate)
          0: if (wr_burst_req) begin
               remaining = int'(wr_burst_len);
               gap = $urandom_range(0, 3);
               cstate = 1;
             end
          1: if (gap == 0) begin
               if (remaining == 0) begin
                 wr_burst_finish = 1'b1;
                 cstate = 3;
               end else begin
                 wr_burst_data_req = 1'b1;
                 remaining--;
                 cstate = 2;
               end
             end else gap--;
          2: if (remaining == 0) begin
               wr_burst_data_req = 1'b0;
               wr_burst_finish = 1'b1;
               cstate = 3;
             end else remaining--;
          default: begin
            wr_burst_finish = 1'b0;
            cstate = 0;
          end
        endcase
      end
    end
  endtask

  initial begin
    logic [AW-1:0] base;
    int len;
    int b0;
    rst = 1'b1;
    write_req = 1'b0;
    write_addr_0 = '0; write_addr_1 = '0; write_addr_2 = '0; write_addr_3 = '0;
    write_addr_index = '0;
    write_len = '0;
    rdusedw = '0;
    wr_burst_data_req = 1'b0;
    wr_burst_finish = 1'b0;
    fork
      monitor_loop();
      ctrl_loop();
    join_none

    repeat (3) @(posedge mem_clk);
    #2;
    check("rst_burst_req", 64'(wr_burst_req), 64'd0);
    check("rst_burst_len", 64'(wr_burst_len), 64'd0);
    check("rst_burst_addr", 64'(wr_burst_addr), 64'd0);
    check("rst_ack", 64'(write_req_ack), 64'd0);
    check("rst_finish", 64'(write_finish), 64'd0);
    check("rst_aclr", 64'(fifo_aclr), 64'd0);
    wr_burst_data_req = 1'b1; #1;
    check("rst_rdreq_hi", 64'(fifo_rdreq), 64'd1);
    wr_burst_data_req = 1'b0; #1;
    check("rst_rdreq_lo", 64'(fifo_rdreq), 64'd0);
    @(posedge mem_clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge mem_clk);

    // Four full bursts from base 0x1000 via index 2.
    rdusedw = 16'd400;
    push_frame(23'h001000, 512, -1);
    exp_fin++;
    do_request(23'h001000, 2'd2, 23'd512, 100);
    wait_finish("len512", 5000);

    // Burst held off until the FIFO holds a full burst.
    rdusedw = 16'd100;
    push_frame(23'h002000, 256, -1);
    exp_fin++;
    do_request(23'h002000, 2'd1, 23'd256, 100);
    repeat (20) @(posedge mem_clk);
    @(negedge mem_clk);
    check("low_fill_no_req", 64'(wr_burst_req), 64'd0);
    @(posedge mem_clk); #1;
    rdusedw = 16'd128;
    @(posedge mem_clk);
    @(negedge mem_clk);
    check("fill_128_req", 64'(wr_burst_req), 64'd1);
    wait_finish("fill", 5000);

    // Non-multiple length and address wrap.
    rdusedw = 16'd1000;
    push_frame(23'h004000, 300, -1);
    exp_fin++;
    do_request(23'h004000, 2'd0, 23'd300, 100);
    wait_finish("len300", 5000);
    push_frame(23'h7FFF80, 256, -1);
    exp_fin++;
    do_request(23'h7FFF80, 2'd3, 23'd256, 100);
    wait_finish("wrap", 5000);

    // New request during the second burst restarts after that burst completes.
    rdusedw = 16'd500;
    push_frame(23'h003000, 512, 2);
    b0 = bursts_seen;
    do_request(23'h003000, 2'd0, 23'd512, 100);
    for (int n = 0; n < 2000 && bursts_seen < b0 + 2; n++) @(posedge mem_clk);
    #2;
    check("second_burst_seen", 64'(bursts_seen - b0), 64'd2);
    push_frame(23'h005000, 384, -1);
    exp_fin++;
    do_request(23'h005000, 2'd1, 23'd384, 1000);
    wait_finish("restart", 5000);

    // Random frames, including a zero-length one.
    for (int i = 0; i < 6; i++) begin
      len = (i == 0) ? 0 : int'($urandom_range(1, 700));
      base = AW'($urandom());
      rdusedw = 16'($urandom_range(128, 2000));
      push_frame(base, len, -1);
      exp_fin++;
      do_request(base, 2'($urandom_range(0, 3)), AW'(len), 100);
      wait_finish("random", 8000);
    end

    // Reset during a burst.
    rdusedw = 16'd400;
    push_frame(23'h006000, 512, -1);
    b0 = bursts_seen;
    do_request(23'h006000, 2'd2, 23'd512, 100);
    for (int n = 0; n < 500 && bursts_seen == b0; n++) @(posedge mem_clk);
    #2;
    check("burst_before_rst", 64'(bursts_seen - b0), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_burst_req", 64'(wr_burst_req), 64'd0);
    check("midrst_burst_len", 64'(wr_burst_len), 64'd0);
    check("midrst_burst_addr", 64'(wr_burst_addr), 64'd0);
    check("midrst_ack", 64'(write_req_ack), 64'd0);
    check("midrst_aclr", 64'(fifo_aclr), 64'd0);
    check("midrst_finish", 64'(write_finish), 64'd0);
    exp_q.delete();
    exp_fin = 0;
    repeat (2) @(posedge mem_clk);
    #1;
    rst = 1'b0;
    repeat (12) @(posedge mem_clk);
    #2;
    check("post_rst_idle_req", 64'(wr_burst_req), 64'd0);
    check("post_rst_idle_ack", 64'(write_req_ack), 64'd0);
    check("post_rst_idle_finish", 64'(write_finish), 64'd0);

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    check("exp_fin_zero", 64'(exp_fin), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
